// File: rtl/yarp_data_ram_pkg.sv
// yarp_data_ram_pkg: access-size encoding, timer register offsets and lane helpers
// shared by the data RAM and its optional timer.
package yarp_data_ram_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b11
    } mem_size_e;

    localparam logic [3:0] MTIME_LO    = 4'h0;
    localparam logic [3:0] MTIME_HI    = 4'h4;
    localparam logic [3:0] MTIMECMP_LO = 4'h8;
    localparam logic [3:0] MTIMECMP_HI = 4'hC;

    function automatic logic [31:0] size_mask(input logic [1:0] size);
        return size == WORD ? 32'hFFFF_FFFF : size == HALF_WORD ? 32'h0000_FFFF : 32'h0000_00FF;
    endfunction

    function automatic logic [3:0] size_lanes(input logic [1:0] size);
        return size == WORD ? 4'b1111 : size == HALF_WORD ? 4'b0011 : 4'b0001;
    endfunction

endpackage

// File: rtl/yarp_data_ram_if.sv
// yarp_data_ram_if: core data-memory port between the YARP core (master) and the data RAM (slave).
interface yarp_data_ram_if;
    logic        req;
    logic        wr;
    logic [1:0]  byte_en;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (output req, wr, byte_en, addr, wr_data, input rd_data);
    modport slave  (input req, wr, byte_en, addr, wr_data, output rd_data);
endinterface

// File: rtl/yarp_data_ram_timer.sv
// yarp_data_ram_timer: 64-bit free-running mtime with mtimecmp and registered compare interrupt.
module yarp_data_ram_timer
    import yarp_data_ram_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we,
    input  logic [3:0]  sel,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    logic [63:0] mtime_q, mtime_d, cmp_q, cmp_d;
    logic        irq_q, irq_d;

    // A store to either mtime half replaces the increment for that cycle.
    always_comb begin
        mtime_d = we && sel == MTIME_LO ? {mtime_q[63:32], wdata} :
                  we && sel == MTIME_HI ? {wdata, mtime_q[31:0]} : mtime_q + 64'd1;
        cmp_d   = we && sel == MTIMECMP_LO ? {cmp_q[63:32], wdata} :
                  we && sel == MTIMECMP_HI ? {wdata, cmp_q[31:0]} : cmp_q;
        irq_d   = mtime_q >= cmp_q;
        rdata   = sel == MTIME_LO    ? mtime_q[31:0]  :
                  sel == MTIME_HI    ? mtime_q[63:32] :
                  sel == MTIMECMP_LO ? cmp_q[31:0]    : cmp_q[63:32];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mtime_q <= '0;
            cmp_q   <= '1;
            irq_q   <= 1'b0;
        end else begin
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            irq_q   <= irq_d;
        end
    end

    assign irq = irq_q;
endmodule

// File: rtl/yarp_data_ram.sv
// yarp_data_ram: byte-addressable data RAM with combinational read, posedge write and
// registered misalign/out-of-range flags; YARP_DMEM_TIMER_EN adds a memory-mapped machine timer.
module yarp_data_ram
    import yarp_data_ram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] TIMER_BASE  = 32'h0000_F000
) (
    input  logic            clk,
    input  logic            reset_n,
    yarp_data_ram_if.slave  bus,
    output logic            misalign_err_o,
    output logic            oor_err_o,
    output logic            timer_irq_o
);
    localparam int          IW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);
`ifdef YARP_DMEM_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] off, wdata, ram_rd, timer_rd;
    logic [IW-1:0] idx;
    logic [3:0]  lanes;
    logic        ram_hit, t_hit, ok, ram_acc, t_acc, ram_we;
    logic        misalign_q, misalign_d, oor_q, oor_d;

    // The timer window only accepts word accesses; anything narrower counts as misaligned.
    always_comb begin
        off        = bus.addr - BASE_ADDR;
        idx        = off[IW+1:2];
        ram_hit    = bus.addr >= BASE_ADDR && off < RAM_BYTES;
        t_hit      = TIMER_EN && bus.addr[31:4] == TIMER_BASE[31:4];
        ok         = (bus.byte_en == BYTE) || (bus.byte_en == HALF_WORD && !bus.addr[0]) ||
                     (bus.byte_en == WORD && bus.addr[1:0] == 2'b00);
        ok         = ok && (!t_hit || bus.byte_en == WORD);
        misalign_d = bus.req && !ok;
        oor_d      = bus.req && ok && !ram_hit && !t_hit;
        ram_acc    = bus.req && ok && ram_hit;
        t_acc      = bus.req && ok && t_hit;
        ram_we     = ram_acc && bus.wr && reset_n;
        lanes      = size_lanes(bus.byte_en) << off[1:0];
        wdata      = bus.wr_data << {off[1:0], 3'b000};
        ram_rd     = (mem[idx] >> {off[1:0], 3'b000}) & size_mask(bus.byte_en);
        bus.rd_data = !reset_n || bus.wr ? 32'h0 : ram_acc ? ram_rd : t_acc ? timer_rd : 32'h0;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_we && lanes[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misalign_q <= 1'b0;
            oor_q      <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
            oor_q      <= oor_d;
        end
    end

    assign misalign_err_o = misalign_q;
    assign oor_err_o      = oor_q;

`ifdef YARP_DMEM_TIMER_EN
    yarp_data_ram_timer u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .we     (t_acc && bus.wr),
        .sel    (bus.addr[3:0]),
        .wdata  (bus.wr_data),
        .rdata  (timer_rd),
        .irq    (timer_irq_o)
    );
`else
    assign timer_rd    = 32'h0;
    assign timer_irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_yarp_data_ram.sv
// tb_yarp_data_ram: directed vectors for the data RAM; timer vectors run when YARP_DMEM_TIMER_EN is defined.
module tb_yarp_data_ram;
    import yarp_data_ram_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic misalign, oor, irq;
    int   vecs = 0;
    int   errs = 0;

    yarp_data_ram_if bus ();

    yarp_data_ram dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus.slave),
        .misalign_err_o(misalign),
        .oor_err_o     (oor),
        .timer_irq_o   (irq)
    );

    always #5 clk = ~clk;

    task automatic put(input logic r, input logic w, input logic [1:0] be, input logic [31:0] a, input logic [31:0] d);
        bus.req = r; bus.wr = w; bus.byte_en = be; bus.addr = a; bus.wr_data = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        put(1, 0, WORD, 32'h2010, 0);
        chk("rst_rd", bus.rd_data, 0);
        chk("rst_errs", {misalign, oor, irq}, 0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        put(1, 1, WORD, 32'h2010, 32'hDEAD_BEEF); tick();
        chk("st_w_errs", {misalign, oor}, 0);
        put(1, 0, WORD, 32'h2010, 0);
        chk("ld_w", bus.rd_data, 32'hDEAD_BEEF);
        put(1, 1, BYTE, 32'h2013, 32'h1234_56A5); tick();
        put(1, 0, HALF_WORD, 32'h2012, 0);
        chk("ld_h_hi", bus.rd_data, 32'h0000_A5AD);
        put(1, 0, WORD, 32'h2010, 0);
        chk("ld_w_after_b", bus.rd_data, 32'hA5AD_BEEF);
        put(1, 0, BYTE, 32'h2011, 0);
        chk("ld_b", bus.rd_data, 32'h0000_00BE);
        put(1, 1, HALF_WORD, 32'h2010, 32'hFFFF_7788); tick();
        put(1, 0, WORD, 32'h2010, 0);
        chk("ld_w_after_h", bus.rd_data, 32'hA5AD_7788);
        put(1, 1, WORD, 32'h2000, 32'hCAFE_F00D); tick();
        put(1, 1, WORD, 32'h2004, 32'h0); tick();
        put(1, 1, WORD, 32'h2002, 32'h1111_1111); tick();
        chk("mis_st_flag", {misalign, oor}, 2'b10);
        put(0, 0, WORD, 32'h0, 0); tick();
        chk("mis_pulse_end", {misalign, oor}, 0);
        put(1, 0, WORD, 32'h2000, 0);
        chk("mis_st_lo", bus.rd_data, 32'hCAFE_F00D);
        put(1, 0, WORD, 32'h2004, 0);
        chk("mis_st_hi", bus.rd_data, 32'h0);
        put(1, 0, 2'b10, 32'h2010, 0);
        chk("sz10_rd", bus.rd_data, 0);
        tick();
        chk("sz10_flag", {misalign, oor}, 2'b10);
        put(1, 0, HALF_WORD, 32'h2011, 0);
        chk("mis_h_rd", bus.rd_data, 0);
        tick();
        chk("b2b_mis_1", misalign, 1);
        put(1, 1, HALF_WORD, 32'h2013, 32'h0); tick();
        chk("b2b_mis_2", misalign, 1);
        put(1, 0, WORD, 32'h2010, 0);
        chk("mis_h_st_nochg", bus.rd_data, 32'hA5AD_7788);
        tick();
        chk("mis_clear", misalign, 0);
        put(1, 1, WORD, 32'h2FFC, 32'h0BAD_C0DE); tick();
        put(1, 0, WORD, 32'h2FFC, 0);
        chk("ld_last", bus.rd_data, 32'h0BAD_C0DE);
        put(1, 0, WORD, 32'h3000, 0);
        chk("oor_rd", bus.rd_data, 0);
        tick();
        chk("oor_flag", {misalign, oor}, 2'b01);
        put(1, 1, WORD, 32'h3000, 32'hFFFF_FFFF); tick();
        chk("oor_st_flag", oor, 1);
        put(1, 0, WORD, 32'h2000, 0);
        chk("oor_st_nowrap", bus.rd_data, 32'hCAFE_F00D);
        tick();
        chk("oor_clear", oor, 0);
        put(1, 0, WORD, 32'h1FFC, 0);
        chk("below_rd", bus.rd_data, 0);
        tick();
        chk("below_flag", oor, 1);
        put(1, 1, WORD, 32'h3001, 32'h0); tick();
        chk("mis_prio", {misalign, oor}, 2'b10);
`ifndef YARP_DMEM_TIMER_EN
        put(1, 0, WORD, 32'hF000, 0);
        chk("tmr_off_rd", bus.rd_data, 0);
        tick();
        chk("tmr_off_oor", {misalign, oor, irq}, 3'b010);
`else
        put(1, 1, WORD, 32'hF008, 32'd20); tick();
        put(1, 1, WORD, 32'hF00C, 32'd0); tick();
        put(1, 1, WORD, 32'hF000, 32'd0); tick();
        put(1, 0, WORD, 32'hF000, 0);
        chk("mtime_set", bus.rd_data, 0);
        for (int k = 0; k < 40 && bus.rd_data !== 32'd20; k++) tick();
        chk("mtime_reach", bus.rd_data, 32'd20);
        chk("irq_lag", irq, 0);
        tick();
        chk("irq_set", irq, 1);
        put(1, 1, WORD, 32'hF000, 32'd0); tick();
        chk("irq_hold", irq, 1);
        put(0, 0, WORD, 0, 0); tick();
        chk("irq_drop", irq, 0);
        put(1, 1, WORD, 32'hF004, 32'hFFFF_FFFF); tick();
        put(1, 1, WORD, 32'hF000, 32'hFFFF_FFFF); tick();
        put(1, 0, WORD, 32'hF004, 0);
        chk("mtime_max_hi", bus.rd_data, 32'hFFFF_FFFF);
        tick();
        chk("mtime_wrap_hi", bus.rd_data, 0);
        put(1, 0, WORD, 32'hF000, 0);
        chk("mtime_wrap_lo", bus.rd_data, 0);
        put(1, 0, HALF_WORD, 32'hF000, 0);
        chk("tmr_half_rd", bus.rd_data, 0);
        tick();
        chk("tmr_half_flag", {misalign, oor}, 2'b10);
`endif
        put(1, 0, 2'b10, 32'h2000, 0); tick();
        chk("pre_rst_flag", misalign, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_clears", {misalign, oor, irq}, 0);
        put(1, 1, WORD, 32'h2000, 32'h5555_5555); tick();
        put(0, 0, WORD, 0, 0);
        reset_n = 1'b1;
        #1;
        chk("rel_outs", {misalign, oor, irq}, 0);
`ifdef YARP_DMEM_TIMER_EN
        put(1, 0, WORD, 32'hF000, 0);
        chk("rel_mtime", bus.rd_data, 0);
        put(1, 0, WORD, 32'hF00C, 0);
        chk("rel_cmp", bus.rd_data, 32'hFFFF_FFFF);
`endif
        put(1, 0, WORD, 32'h2000, 0);
        chk("rst_st_drop", bus.rd_data, 32'hCAFE_F00D);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
